// File: rtl/cat_apb_sequencer.sv
// APB master that loads one CatRecognizer run from a valid/ready word source,
// starts the engine, polls its status register and captures the verdict.
module cat_apb_sequencer #(
  parameter int unsigned Amba_Word       = 24,
  parameter int unsigned Amba_Addr_Depth = 12,
  parameter int unsigned DATA_BASE       = 4,
  parameter int unsigned NUM_WORDS       = 1024,
  parameter int unsigned CTRL_ADDR       = 0,
  parameter int unsigned STATUS_ADDR     = 1,
  parameter int unsigned POLL_GAP        = 8,
  parameter int unsigned TIMEOUT_CYCLES  = 65535
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       go,
  output logic                       busy,
  input  logic [Amba_Word-1:0]       src_data,
  input  logic                       src_valid,
  output logic                       src_ready,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  output logic [Amba_Addr_Depth-1:0] PADDR,
  output logic [Amba_Word-1:0]       PWDATA,
  input  logic [Amba_Word-1:0]       PRDATA,
  input  logic                       CatRecOut,
  output logic                       result,
  output logic                       result_valid,
  output logic                       err
);

  localparam int unsigned AW    = Amba_Addr_Depth;
  localparam int unsigned DW    = Amba_Word;
  localparam int unsigned CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned GAP_W = $clog2(POLL_GAP + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [AW-1:0]    BASE_A   = AW'(DATA_BASE);
  localparam logic [AW-1:0]    CTRL_A   = AW'(CTRL_ADDR);
  localparam logic [AW-1:0]    STAT_A   = AW'(STATUS_ADDR);

  typedef enum logic [3:0] {
    IDLE, LD_WAIT, LD_SETUP, LD_ACCESS, ST_SETUP, ST_ACCESS, POLL_WAIT, PL_SETUP, PL_ACCESS
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [AW-1:0]    addr, addr_nxt;
  logic [GAP_W-1:0] gap, gap_nxt;
  logic [TMO_W-1:0] tmo, tmo_nxt, tmo_inc;

  logic          busy_nxt, src_ready_nxt, psel_nxt, penable_nxt, pwrite_nxt;
  logic [AW-1:0] paddr_nxt;
  logic [DW-1:0] pwdata_nxt;
  logic          result_nxt, result_valid_nxt, err_nxt;

  // Only the done flag of the status word matters; upper bits are don't-care.
  logic unused_prdata;
  assign unused_prdata = ^PRDATA[DW-1:1];

  // Saturating poll-phase cycle count, including the current cycle.
  assign tmo_inc = (tmo == TMO_MAX) ? tmo : tmo + TMO_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      addr         <= '0;
      gap          <= '0;
      tmo          <= '0;
      busy         <= 1'b0;
      src_ready    <= 1'b0;
      PSEL         <= 1'b0;
      PENABLE      <= 1'b0;
      PWRITE       <= 1'b0;
      PADDR        <= '0;
      PWDATA       <= '0;
      result       <= 1'b0;
      result_valid <= 1'b0;
      err          <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      addr         <= addr_nxt;
      gap          <= gap_nxt;
      tmo          <= tmo_nxt;
      busy         <= busy_nxt;
      src_ready    <= src_ready_nxt;
      PSEL         <= psel_nxt;
      PENABLE      <= penable_nxt;
      PWRITE       <= pwrite_nxt;
      PADDR        <= paddr_nxt;
      PWDATA       <= pwdata_nxt;
      result       <= result_nxt;
      result_valid <= result_valid_nxt;
      err          <= err_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    cnt_nxt          = cnt;
    addr_nxt         = addr;
    gap_nxt          = gap;
    tmo_nxt          = tmo;
    pwrite_nxt       = PWRITE;
    paddr_nxt        = PADDR;
    pwdata_nxt       = PWDATA;
    result_nxt       = result;
    result_valid_nxt = 1'b0;
    err_nxt          = err;

    case (state)
      IDLE: begin
        if (go) begin
          state_nxt  = LD_WAIT;
          err_nxt    = 1'b0;
          result_nxt = 1'b0;
          cnt_nxt    = '0;
          addr_nxt   = BASE_A;
        end
      end
      LD_WAIT: begin
        if (src_valid) begin
          state_nxt  = LD_SETUP;
          pwdata_nxt = src_data;
          paddr_nxt  = addr;
          pwrite_nxt = 1'b1;
        end
      end
      LD_SETUP: state_nxt = LD_ACCESS;
      LD_ACCESS: begin
        if (cnt == LAST_CNT) begin
          state_nxt  = ST_SETUP;
          paddr_nxt  = CTRL_A;
          pwdata_nxt = DW'(1);
          pwrite_nxt = 1'b1;
        end else begin
          state_nxt = LD_WAIT;
          cnt_nxt   = cnt + CNT_W'(1);
          addr_nxt  = addr + AW'(1);
        end
      end
      ST_SETUP: state_nxt = ST_ACCESS;
      ST_ACCESS: begin
        state_nxt = POLL_WAIT;
        tmo_nxt   = '0;
        gap_nxt   = '0;
      end
      POLL_WAIT: begin
        tmo_nxt = tmo_inc;
        if (tmo_inc == TMO_MAX) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
        end else if (gap == GAP_LAST) begin
          state_nxt  = PL_SETUP;
          paddr_nxt  = STAT_A;
          pwrite_nxt = 1'b0;
        end else begin
          gap_nxt = gap + GAP_W'(1);
        end
      end
      PL_SETUP: begin
        tmo_nxt   = tmo_inc;
        state_nxt = PL_ACCESS;
      end
      PL_ACCESS: begin
        // An open read always completes; a done status wins over expiry.
        tmo_nxt = tmo_inc;
        if (PRDATA[0]) begin
          state_nxt        = IDLE;
          result_nxt       = CatRecOut;
          result_valid_nxt = 1'b1;
        end else if (tmo_inc == TMO_MAX) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
        end else begin
          state_nxt = POLL_WAIT;
          gap_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase

    psel_nxt      = (state_nxt == LD_SETUP)  || (state_nxt == LD_ACCESS) ||
                    (state_nxt == ST_SETUP)  || (state_nxt == ST_ACCESS) ||
                    (state_nxt == PL_SETUP)  || (state_nxt == PL_ACCESS);
    penable_nxt   = (state_nxt == LD_ACCESS) || (state_nxt == ST_ACCESS) ||
                    (state_nxt == PL_ACCESS);
    src_ready_nxt = (state_nxt == LD_WAIT);
    busy_nxt      = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_cat_apb_sequencer.sv
// Randomized bench for cat_apb_sequencer: source and APB slave models, a bus
// monitor, and expectations derived from transfer-level timing rules.
module tb_cat_apb_sequencer;

  localparam int unsigned AW  = 12;
  localparam int unsigned DW  = 24;
  localparam int unsigned DW1 = DW - 1;
  localparam int unsigned NW  = 4;
  localparam int unsigned DB  = 4;
  localparam int unsigned CA  = 0;
  localparam int unsigned SA  = 1;
  localparam int unsigned GAP = 8;
  localparam int unsigned TMO = 50;

  logic          clk = 1'b0;
  logic          rst, go, busy;
  logic [DW-1:0] src_data;
  logic          src_valid, src_ready;
  logic          PSEL, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;
  logic          CatRecOut, result, result_valid, err;

  cat_apb_sequencer #(
    .Amba_Word(DW), .Amba_Addr_Depth(AW), .DATA_BASE(DB), .NUM_WORDS(NW),
    .CTRL_ADDR(CA), .STATUS_ADDR(SA), .POLL_GAP(GAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .go(go), .busy(busy),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .CatRecOut(CatRecOut),
    .result(result), .result_valid(result_valid), .err(err)
  );

  initial forever #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // source model state
  logic [DW-1:0] src_q[$];
  int            src_dly[$];
  int            acc_cyc[$];
  int            dly_left = -1;
  bit            hs = 1'b0;
  logic [DW-1:0] run_words[$];
  int            run_dly[$];

  // monitor / slave state
  logic [AW-1:0] m_addr[$];
  bit            m_wr[$];
  logic [DW-1:0] m_data[$];
  int            m_cyc[$];
  bit            prev_setup = 1'b0;
  logic [AW-1:0] s_addr;
  bit            s_wr;
  logic [DW-1:0] s_data;
  int            s_cyc;
  int            proto_err = 0;
  int            read_idx = 0;
  int            done_after = 0;
  bit            verdict = 1'b0;
  int            rv_cnt = 0;
  int            rv_cyc = 0;
  int            err_cyc = 0;
  bit            err_seen = 1'b0;
  int            go_cyc = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // APB monitor and status-register slave, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (PSEL && !PENABLE) begin
      if (prev_setup) proto_err++;
      prev_setup = 1'b1;
      s_addr = PADDR; s_wr = PWRITE; s_data = PWDATA; s_cyc = cyc;
      if (!PWRITE) begin
        PRDATA    = {DW1'($urandom), 1'(read_idx >= done_after)};
        CatRecOut = (read_idx >= done_after) ? verdict : 1'($urandom);
        read_idx++;
      end
    end else if (PSEL && PENABLE) begin
      if (!prev_setup || PADDR !== s_addr || PWRITE !== s_wr || (PWRITE && PWDATA !== s_data))
        proto_err++;
      prev_setup = 1'b0;
      m_addr.push_back(PADDR);
      m_wr.push_back(PWRITE);
      m_data.push_back(PWRITE ? PWDATA : PRDATA);
      m_cyc.push_back(s_cyc);
    end else begin
      if (PENABLE || prev_setup) proto_err++;
      prev_setup = 1'b0;
    end
    if (result_valid) begin
      rv_cnt++;
      rv_cyc = cyc;
    end
    if (err && !err_seen) begin
      err_seen = 1'b1;
      err_cyc  = cyc;
    end
  end

  // Word source: each word is offered after its own number of idle cycles.
  initial forever begin
    @(negedge clk);
    #2;
    if (hs) begin
      void'(src_q.pop_front());
      void'(src_dly.pop_front());
      dly_left  = -1;
      src_valid = 1'b0;
    end
    if (!src_valid && src_q.size() > 0) begin
      if (dly_left < 0) dly_left = src_dly[0];
      if (dly_left == 0) begin
        src_valid = 1'b1;
        src_data  = src_q[0];
      end else begin
        dly_left--;
      end
    end
    hs = src_valid && src_ready && !rst;
    if (hs) acc_cyc.push_back(cyc);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_random(input int max_dly);
    run_words.delete();
    run_dly.delete();
    for (int i = 0; i < NW; i++) begin
      run_words.push_back(DW'($urandom));
      run_dly.push_back($urandom_range(0, max_dly));
    end
  endtask

  task automatic start_go(input int da, input bit vd);
    done_after = da;
    verdict    = vd;
    read_idx   = 0;
    for (int i = 0; i < NW; i++) begin
      src_q.push_back(run_words[i]);
      src_dly.push_back(run_dly[i]);
    end
    repeat (6) tick();
    go = 1'b1;
    go_cyc = cyc;
    tick();
    go = 1'b0;
    m_addr.delete(); m_wr.delete(); m_data.delete(); m_cyc.delete();
    acc_cyc.delete();
    rv_cnt = 0; err_seen = 1'b0; proto_err = 0;
    chk("busy_after_go", busy, 1);
    chk("err_cleared_by_go", err, 0);
    chk("src_ready_after_go", src_ready, 1);
  endtask

  task automatic do_run(input int da, input bit vd, input bit jitter, input bit to);
    bit ended;
    int reads_exp, end_t, ctrl_c, nexp, sp;
    start_go(da, vd);
    ended = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      if (rv_cnt > 0 || err_seen) begin
        ended = 1'b1;
        break;
      end
      go = (jitter && m_addr.size() < NW - 1) ? 1'($urandom) : 1'b0;
      tick();
    end
    go = 1'b0;
    chk("run_finished", ended, 1);
    chk("idle_at_end", busy, 0);
    chk("psel_low_at_end", PSEL, 0);

    if (!to) begin
      reads_exp = da + 1;
    end else begin
      end_t = TMO - 1;
      if (((TMO - 1) % (GAP + 2)) == GAP) end_t = end_t + 1;
      reads_exp = (end_t >= GAP + 1) ? (end_t - GAP - 1) / (GAP + 2) + 1 : 0;
    end
    nexp = NW + 1 + reads_exp;
    chk("accept_count", acc_cyc.size(), NW);
    chk("xfer_count", m_addr.size(), nexp);
    if (m_addr.size() == nexp && acc_cyc.size() == NW) begin
      if (run_dly[0] == 0) chk("first_psel_cycle", m_cyc[0], go_cyc + 2);
      for (int i = 0; i < NW; i++) begin
        chk("load_addr", m_addr[i], DB + i);
        chk("load_write", m_wr[i], 1);
        chk("load_data", m_data[i], run_words[i]);
        chk("load_setup_cycle", m_cyc[i], acc_cyc[i] + 1);
        if (i > 0) begin
          sp = (run_dly[i] + 1 > 3) ? run_dly[i] + 1 : 3;
          chk("load_spacing", m_cyc[i] - m_cyc[i-1], sp);
        end
      end
      ctrl_c = m_cyc[NW];
      chk("ctrl_addr", m_addr[NW], CA);
      chk("ctrl_write", m_wr[NW], 1);
      chk("ctrl_data", m_data[NW], 1);
      chk("ctrl_cycle", ctrl_c, m_cyc[NW-1] + 2);
      for (int r = 0; r < reads_exp; r++) begin
        chk("poll_addr", m_addr[NW+1+r], SA);
        chk("poll_read", m_wr[NW+1+r], 0);
        chk("poll_cycle", m_cyc[NW+1+r], ctrl_c + (r + 1) * (GAP + 2));
      end
      if (!to) begin
        chk("result_valid_cycle", rv_cyc, m_cyc[nexp-1] + 2);
        chk("result_valid_count", rv_cnt, 1);
        chk("result_value", result, vd);
        chk("err_low", err, 0);
      end else begin
        chk("timeout_cycle", err_cyc, ctrl_c + 2 + end_t + 1);
        chk("timeout_bound", (err_cyc - (ctrl_c + 2)) <= int'(TMO + 2), 1);
        chk("no_result_on_timeout", rv_cnt, 0);
        chk("err_high", err, 1);
      end
    end
    chk("apb_protocol", proto_err, 0);
    tick();
    chk("result_valid_pulse", result_valid, 0);
    if (!to) chk("result_held", result, vd);
  endtask

  initial begin
    bit found;
    rst = 1'b1; go = 1'b1; src_valid = 1'b0; src_data = '0;
    PRDATA = '0; CatRecOut = 1'b0;
    repeat (2) tick();
    chk("rst_busy", busy, 0);
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_pwrite", PWRITE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_src_ready", src_ready, 0);
    chk("rst_result", result, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_err", err, 0);
    rst = 1'b0; go = 1'b0;
    repeat (2) tick();
    chk("go_during_rst_ignored", busy, 0);

    // directed words, always valid, done on third read
    run_words = '{24'h0000A1, 24'h0000A2, 24'h0000A3, 24'h0000A4};
    run_dly   = '{0, 0, 0, 0};
    do_run(2, 1'b1, 1'b0, 1'b0);

    // source stalls five cycles before the third word
    fill_random(0);
    run_dly[2] = 5;
    do_run($urandom_range(0, 3), 1'($urandom), 1'b0, 1'b0);
    chk("stall_gap_spacing", m_cyc[2] - m_cyc[1], 6);

    // status never done
    fill_random(2);
    do_run(1000, 1'b1, 1'b0, 1'b1);

    // next run clears err; go jitter while busy
    fill_random(3);
    do_run($urandom_range(0, 3), 1'($urandom), 1'b1, 1'b0);

    // reset during a load ACCESS cycle
    fill_random(1);
    start_go(0, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (PSEL && PENABLE && PWRITE && m_addr.size() >= 2 && PADDR !== AW'(CA)) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("abort_point_reached", found, 1);
    rst = 1'b1;
    tick();
    chk("abort_psel", PSEL, 0);
    chk("abort_penable", PENABLE, 0);
    chk("abort_busy", busy, 0);
    chk("abort_src_ready", src_ready, 0);
    rst = 1'b0;
    src_q.delete(); src_dly.delete(); dly_left = -1; hs = 1'b0; src_valid = 1'b0;
    tick();
    fill_random(3);
    do_run($urandom_range(0, 3), 1'($urandom), 1'b0, 1'b0);

    for (int n = 0; n < 3; n++) begin
      fill_random(3);
      do_run($urandom_range(0, 3), 1'($urandom), 1'($urandom), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
